pmem_arbiter: RTL
=================

// Module: pmem_arbiter
// PURPOSE
//  Responder for the datapath's two cache-line pmem ports (I and D): accepts 256-bit line
//  read/write requests, arbitrates them onto one burst memory port, and returns a
//  one-cycle *_resp. Sits between datapath (or L2) and physical memory.
//  One request in flight at a time. Each line is moved as BURST_LEN beats of DATA_W bits.
// PARAMETERS
//  DATA_W     64  burst beat width, bits
//  BURST_LEN  4   beats per line; DATA_W*BURST_LEN must equal 256 (elaboration $error otherwise)
// PORTS
//  clk            in   1    clock; all logic on posedge
//  rst            in   1    synchronous, active-high reset
//  pmem_iread     in   1    I-side line read request, held until pmem_iresp
//  pmem_iwrite    in   1    I-side line write request, held until pmem_iresp
//  pmem_iaddress  in   32   I-side byte address; bits [4:0] ignored
//  pmem_iwdata    in   256  I-side write line
//  pmem_iresp     out  1    I-side done pulse, one cycle
//  pmem_irdata    out  256  I-side read line, valid while pmem_iresp=1
//  pmem_dread/pmem_dwrite/pmem_daddress/pmem_dwdata/pmem_dresp/pmem_drdata: D-side, same as I
//  pmem_dmbe      in   4    accepted, unused (line transfers are always full-line)
//  mem_read       out  1    burst read command, held until last beat
//  mem_write      out  1    burst write command, held until last beat
//  mem_address    out  32   {line_addr[31:5],5'b0}, stable for the whole burst
//  mem_wdata      out  64   current write beat
//  mem_rdata      in   64   current read beat, valid when mem_resp=1
//  mem_resp       in   1    beat accept/valid; one per beat, gaps allowed
// BEHAVIOUR
//  Reset: state=IDLE, beat=0, owner=D. All outputs 0, including line buffers.
//  FSM: IDLE -> RD|WR -> DONE -> IDLE.
//  - IDLE: a request is a port with read|write set. If any request: latch owner, address,
//    direction and wdata; go to RD (read) or WR (write). Else stay in IDLE.
//  - RD: mem_read=1. Each mem_resp stores mem_rdata into line[beat*64 +: 64] and increments
//    beat. On the resp where beat==BURST_LEN-1: go to DONE and clear beat.
//  - WR: mem_write=1, mem_wdata=wline[beat*64 +: 64]. Beat advances on mem_resp.
//    Exit on the last beat, same as RD.
//  - DONE: one cycle; the owner's *_resp=1. The owner's *_rdata = assembled line (reads
//    only; 0 after writes). The non-owner's resp stays 0. Then go to IDLE.
//  Latency: read/write = 1 (IDLE accept) + BURST_LEN mem_resp cycles + 1 (DONE) with zero
//    memory gaps. Back-to-back with zero gaps = BURST_LEN+2 cycles per line.
//  IDLE takes a fresh decision every time. Requesters drop the request the cycle after
//    resp, so a serviced request is never re-accepted.
//  Arbitration: fixed D-over-I priority when both request in the same IDLE cycle.
//  Request read and write both high on one port: write is serviced. The sim-only
//    assertion pmem_arbiter_rw_conflict fires.
//  Address/wdata changes by a requester after acceptance are ignored (latched in IDLE).
//  mem_resp outside RD/WR is ignored.
//  Beat counter width: $clog2(BURST_LEN). No wrap other than the explicit clear at last beat.
//  Reset mid-burst: back to IDLE in the next cycle, beat cleared, mem_read/write drop.
//    No resp is issued for the aborted request. Memory must tolerate the abandoned burst.
// CONFIGURATION
//  PMEM_ARB_RR_EN defined: round-robin instead of fixed priority.
//  - Only on a simultaneous I+D request in IDLE, the port not served last wins.
//  - last_owner resets to I, so D wins the first tie.
//  - last_owner is updated at each DONE.
//  Not defined: fixed D priority; no last_owner state.
// TESTING
//  1 D read 0x0000_1234, mem beats A0..A3 no gaps -> mem_address=0x0000_1220;
//    pmem_dresp 1 cycle at accept+5; drdata={A3,A2,A1,A0}.
//  2 I write 0x8000_0040, iwdata={W3,W2,W1,W0}, mem_resp with 2-cycle gaps ->
//    mem_wdata W0,W1,W2,W3 in order; mem_write held until beat 3; pmem_iresp 1 cycle, irdata=0.
//  3 I and D read in the same cycle, both held -> D first, then I.
//    With PMEM_ARB_RR_EN: D first after reset, I on the next tie, D on the one after.
//  4 rst=1 after beat 1 of a read -> next cycle IDLE, mem_read=0, no dresp.
//    A new I read then completes normally.
//  5 Back-to-back D reads, each request dropped after resp -> exactly two bursts,
//    two dresp pulses, 6 cycles apart with zero-gap memory.
//  6 pmem_dread and pmem_dwrite both high -> write burst issued, assertion flagged.
//    Stray mem_resp while IDLE -> no state change.

Source files
------------

// File: rtl/pmem_arbiter.sv
// Two-port (I/D) cache-line arbiter onto a single burst memory port, one line in flight.
// Optional: define PMEM_ARB_RR_EN for round-robin tie-breaking instead of fixed D priority.
module pmem_arbiter #(
    parameter int DATA_W    = 64,
    parameter int BURST_LEN = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                pmem_iread,
    input  logic                pmem_iwrite,
    input  logic [31:0]         pmem_iaddress,
    input  logic [255:0]        pmem_iwdata,
    output logic                pmem_iresp,
    output logic [255:0]        pmem_irdata,

    input  logic                pmem_dread,
    input  logic                pmem_dwrite,
    input  logic [31:0]         pmem_daddress,
    input  logic [255:0]        pmem_dwdata,
    input  logic [3:0]          pmem_dmbe,
    output logic                pmem_dresp,
    output logic [255:0]        pmem_drdata,

    output logic                mem_read,
    output logic                mem_write,
    output logic [31:0]         mem_address,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_resp
);

    localparam int LINE_W = 256;
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    generate
        if (DATA_W * BURST_LEN != LINE_W) begin : g_width_check
            $error("pmem_arbiter: DATA_W*BURST_LEN must equal 256");
        end
    endgenerate

    typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_DONE} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    state_t              state_reg, state_next;
    logic [BEAT_W-1:0]   beat_reg, beat_next;
    owner_t              owner_reg, owner_next;
    logic [26:0]         line_addr_reg, line_addr_next;
    logic                is_write_reg, is_write_next;
    logic                load_wline;

    logic [DATA_W-1:0]   wbeat_reg [BURST_LEN];
    logic [DATA_W-1:0]   rbeat_reg [BURST_LEN];
    logic [LINE_W-1:0]   rline;
    logic [LINE_W-1:0]   sel_wline;
    logic [LINE_W-1:0]   done_rdata;

    logic i_req, d_req, pick_d, accept;

    // Line-granular transfers: byte enables and the in-line offset carry no information here.
    logic unused_bits;
    assign unused_bits = ^{pmem_dmbe, pmem_iaddress[4:0], pmem_daddress[4:0]};

    assign i_req  = pmem_iread | pmem_iwrite;
    assign d_req  = pmem_dread | pmem_dwrite;
    assign accept = i_req | d_req;

`ifdef PMEM_ARB_RR_EN
    owner_t last_owner_reg;

    // On a tie, the port that did not complete the most recent transfer wins.
    assign pick_d = d_req & (~i_req | (last_owner_reg == OWN_I));

    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner_reg <= OWN_I;
        end else if (state_reg == ST_DONE) begin
            last_owner_reg <= owner_reg;
        end
    end
`else
    assign pick_d = d_req;
`endif

    assign sel_wline = pick_d ? pmem_dwdata : pmem_iwdata;

    always_comb begin
        state_next     = state_reg;
        beat_next      = beat_reg;
        owner_next     = owner_reg;
        line_addr_next = line_addr_reg;
        is_write_next  = is_write_reg;
        load_wline     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    owner_next     = pick_d ? OWN_D : OWN_I;
                    line_addr_next = pick_d ? pmem_daddress[31:5] : pmem_iaddress[31:5];
                    // A port asserting both read and write gets the write.
                    is_write_next  = pick_d ? pmem_dwrite : pmem_iwrite;
                    load_wline     = 1'b1;
                    state_next     = is_write_next ? ST_WR : ST_RD;
                end
            end
            ST_RD, ST_WR: begin
                if (mem_resp) begin
                    if (beat_reg == LAST_BEAT) begin
                        beat_next  = '0;
                        state_next = ST_DONE;
                    end else begin
                        beat_next  = beat_reg + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            beat_reg      <= '0;
            owner_reg     <= OWN_D;
            line_addr_reg <= '0;
            is_write_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            beat_reg      <= beat_next;
            owner_reg     <= owner_next;
            line_addr_reg <= line_addr_next;
            is_write_reg  <= is_write_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BURST_LEN; gi++) begin : g_beat
            always_ff @(posedge clk) begin
                if (rst) begin
                    wbeat_reg[gi] <= '0;
                end else if (load_wline) begin
                    wbeat_reg[gi] <= sel_wline[gi*DATA_W +: DATA_W];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rbeat_reg[gi] <= '0;
                end else if (state_reg == ST_RD && mem_resp && beat_reg == BEAT_W'(gi)) begin
                    rbeat_reg[gi] <= mem_rdata;
                end
            end

            assign rline[gi*DATA_W +: DATA_W] = rbeat_reg[gi];
        end
    endgenerate

    assign mem_read    = (state_reg == ST_RD);
    assign mem_write   = (state_reg == ST_WR);
    assign mem_address = {line_addr_reg, 5'b0};
    assign mem_wdata   = (state_reg == ST_WR) ? wbeat_reg[beat_reg] : '0;

    // Read data is only presented on the DONE cycle of a read; writes return zero.
    assign done_rdata  = (state_reg == ST_DONE && !is_write_reg) ? rline : '0;

    assign pmem_iresp  = (state_reg == ST_DONE) && (owner_reg == OWN_I);
    assign pmem_dresp  = (state_reg == ST_DONE) && (owner_reg == OWN_D);
    assign pmem_irdata = (owner_reg == OWN_I) ? done_rdata : '0;
    assign pmem_drdata = (owner_reg == OWN_D) ? done_rdata : '0;

`ifndef SYNTHESIS
    pmem_arbiter_rw_conflict: assert property (@(posedge clk) disable iff (rst)
        !((pmem_iread && pmem_iwrite) || (pmem_dread && pmem_dwrite)))
        else $warning("pmem_arbiter: read and write requested together on one port, write serviced");
`endif

endmodule
